// File: rtl/laser_pkg.sv
// Shared types for the laser host: FSM states, default sizing, point format
// and the squared-distance helper used by the coverage check.
package laser_pkg;

  localparam int NPTS_DEF   = 40;
  localparam int RADIUS_DEF = 4;

  typedef logic [3:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DONE = 3'd1,
    FEED      = 3'd2,
    WAIT_RES  = 3'd3,
    SCORE     = 3'd4,
    REPORT    = 3'd5
  } state_t;

  // dx and dy are 4-bit magnitudes, so the squared sum always fits 9 bits
  function automatic logic [8:0] dist2(input coord_t ax, input coord_t ay,
                                       input coord_t bx, input coord_t by);
    logic [3:0] dx;
    logic [3:0] dy;
    logic [7:0] sx;
    logic [7:0] sy;
    dx = (ax >= bx) ? (ax - bx) : (bx - ax);
    dy = (ay >= by) ? (ay - by) : (by - ay);
    sx = {4'd0, dx} * {4'd0, dx};
    sy = {4'd0, dy} * {4'd0, dy};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

endpackage

// File: rtl/laser_cover_chk.sv
// Combinational check of one point against two circle centres.
// Present only when LASER_HOST_SCORE_EN is defined.
`ifdef LASER_HOST_SCORE_EN
module laser_cover_chk
  import laser_pkg::*;
#(
  parameter int RADIUS = RADIUS_DEF
) (
  input  point_t i_pt,
  input  coord_t i_c1x,
  input  coord_t i_c1y,
  input  coord_t i_c2x,
  input  coord_t i_c2y,
  output logic   o_covered
);

  localparam logic [8:0] R2 = 9'(RADIUS * RADIUS);

  logic [8:0] w_d1;
  logic [8:0] w_d2;

  // A point inside both circles still yields a single covered bit
  always_comb begin
    w_d1      = dist2(i_pt.x, i_pt.y, i_c1x, i_c1y);
    w_d2      = dist2(i_pt.x, i_pt.y, i_c2x, i_c2y);
    o_covered = 1'b0;
    if ((w_d1 <= R2) || (w_d2 <= R2)) begin
      o_covered = 1'b1;
    end else begin
      o_covered = 1'b0;
    end
  end

endmodule
`endif

// File: rtl/laser_host.sv
// Host-side driver for the two-circle laser coverage engine: buffers a job,
// streams it on X/Y, captures the result. Scoring is built with LASER_HOST_SCORE_EN.
module laser_host
  import laser_pkg::*;
#(
  parameter int NPTS   = NPTS_DEF,
  parameter int RADIUS = RADIUS_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       wr_en,
  input  logic [5:0] wr_idx,
  input  logic [3:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic       go,
  output logic       busy,
  output logic [3:0] X,
  output logic [3:0] Y,
  input  logic       DONE,
  input  logic [3:0] C1X,
  input  logic [3:0] C1Y,
  input  logic [3:0] C2X,
  input  logic [3:0] C2Y,
  output logic [3:0] res_c1x,
  output logic [3:0] res_c1y,
  output logic [3:0] res_c2x,
  output logic [3:0] res_c2y,
  output logic [5:0] res_score,
  output logic       res_valid
);

  localparam logic [5:0] NPTS_W = 6'(NPTS);
  localparam logic [5:0] LAST   = 6'(NPTS - 1);

  state_t     r_state;
  logic [5:0] r_idx;
  logic       r_busy;
  coord_t     r_x;
  coord_t     r_y;
  coord_t     r_c1x;
  coord_t     r_c1y;
  coord_t     r_c2x;
  coord_t     r_c2y;
  logic       r_valid;
  logic       r_done_low;
  point_t     r_buf [NPTS];

  logic [5:0] w_rd_idx;
  point_t     w_rd_pt;

  // Single read port: point 0 when arming, the next point while feeding, else idx
  always_comb begin
    w_rd_idx = r_idx;
    if (r_state == WAIT_DONE) begin
      w_rd_idx = 6'd0;
    end else if ((r_state == FEED) && (r_idx != LAST)) begin
      w_rd_idx = r_idx + 6'd1;
    end else begin
      w_rd_idx = r_idx;
    end
  end

  assign w_rd_pt = r_buf[w_rd_idx];

  // Point buffer: loaded only while idle and deliberately left out of reset
  always_ff @(posedge CLK) begin
    if (wr_en && (r_state == IDLE) && (wr_idx < NPTS_W)) begin
      r_buf[wr_idx] <= {wr_x, wr_y};
    end
  end

`ifdef LASER_HOST_SCORE_EN
  logic [5:0] r_score;
  logic       w_covered;

  laser_cover_chk #(.RADIUS(RADIUS)) u_cover_chk (
    .i_pt      (w_rd_pt),
    .i_c1x     (r_c1x),
    .i_c1y     (r_c1y),
    .i_c2x     (r_c2x),
    .i_c2y     (r_c2y),
    .o_covered (w_covered)
  );

  assign res_score = r_score;
`else
  assign res_score = 6'd0;
`endif

  // Job sequencer with registered stream, handshake and result outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_idx      <= 6'd0;
      r_busy     <= 1'b0;
      r_x        <= 4'd0;
      r_y        <= 4'd0;
      r_c1x      <= 4'd0;
      r_c1y      <= 4'd0;
      r_c2x      <= 4'd0;
      r_c2y      <= 4'd0;
      r_valid    <= 1'b0;
      r_done_low <= 1'b0;
`ifdef LASER_HOST_SCORE_EN
      r_score    <= 6'd0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (go) begin
            r_busy  <= 1'b1;
            r_state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (DONE) begin
            r_x     <= w_rd_pt.x;
            r_y     <= w_rd_pt.y;
            r_idx   <= 6'd0;
            r_state <= FEED;
          end
        end
        FEED: begin
          if (r_idx == LAST) begin
            r_x        <= 4'd0;
            r_y        <= 4'd0;
            r_done_low <= 1'b0;
            r_state    <= WAIT_RES;
          end else begin
            r_idx <= r_idx + 6'd1;
            r_x   <= w_rd_pt.x;
            r_y   <= w_rd_pt.y;
          end
        end
        // DONE still high from the arming handshake must drop before it counts
        WAIT_RES: begin
          if (!DONE) begin
            r_done_low <= 1'b1;
          end else if (r_done_low) begin
            r_c1x <= C1X;
            r_c1y <= C1Y;
            r_c2x <= C2X;
            r_c2y <= C2Y;
            r_idx <= 6'd0;
`ifdef LASER_HOST_SCORE_EN
            r_score <= 6'd0;
            r_state <= SCORE;
`else
            r_state <= REPORT;
`endif
          end
        end
`ifdef LASER_HOST_SCORE_EN
        SCORE: begin
          r_score <= r_score + {5'd0, w_covered};
          if (r_idx == LAST) begin
            r_state <= REPORT;
          end else begin
            r_idx <= r_idx + 6'd1;
          end
        end
`endif
        REPORT: begin
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign X         = r_x;
  assign Y         = r_y;
  assign res_c1x   = r_c1x;
  assign res_c1y   = r_c1y;
  assign res_c2x   = r_c2x;
  assign res_c2y   = r_c2y;
  assign res_valid = r_valid;

endmodule

// File: tb/tb_laser_host.sv
// Self-checking bench for laser_host: scoreboarded feed stream and result checks,
// with expectations adapted to whether LASER_HOST_SCORE_EN is defined.
module tb_laser_host;

  localparam int NPTS   = 40;
  localparam int RADIUS = 4;
`ifdef LASER_HOST_SCORE_EN
  localparam bit SCORE_ON = 1'b1;
`else
  localparam bit SCORE_ON = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] c1x;
    logic [3:0] c1y;
    logic [3:0] c2x;
    logic [3:0] c2y;
    logic [5:0] score;
  } res_t;

  logic       CLK = 1'b0;
  logic       RST;
  logic       wr_en;
  logic [5:0] wr_idx;
  logic [3:0] wr_x;
  logic [3:0] wr_y;
  logic       go;
  logic       busy;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic [3:0] res_c1x;
  logic [3:0] res_c1y;
  logic [3:0] res_c2x;
  logic [3:0] res_c2y;
  logic [5:0] res_score;
  logic       res_valid;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          bm_x [NPTS];
  int          bm_y [NPTS];
  logic [7:0]  feed_q [$];
  res_t        res_q [$];
  logic [15:0] prev_res = 16'h0000;

  laser_host #(.NPTS(NPTS), .RADIUS(RADIUS)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .go(go), .busy(busy), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_score(res_score), .res_valid(res_valid)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_point(input int k, input int px, input int py);
    wr_en  = 1'b1;
    wr_idx = 6'(k);
    wr_x   = 4'(px);
    wr_y   = 4'(py);
    tick();
    wr_en  = 1'b0;
    bm_x[k] = px;
    bm_y[k] = py;
  endtask

  function automatic int model_score(input int a, input int b, input int c, input int d);
    int cnt;
    int d1;
    int d2;
    cnt = 0;
    for (int k = 0; k < NPTS; k++) begin
      d1 = (bm_x[k] - a) * (bm_x[k] - a) + (bm_y[k] - b) * (bm_y[k] - b);
      d2 = (bm_x[k] - c) * (bm_x[k] - c) + (bm_y[k] - d) * (bm_y[k] - d);
      if ((d1 <= RADIUS * RADIUS) || (d2 <= RADIUS * RADIUS)) cnt++;
    end
    return cnt;
  endfunction

  // One full job: arm, feed check, optional stale-DONE/gated-write variants, capture, report
  task automatic run_job(input string name, input int a, input int b, input int c, input int d,
                         input int low_cycles, input bit stale, input bit gate_write);
    int         n;
    int         exp_lat;
    logic [7:0] e;
    res_t       r;
    exp_lat = SCORE_ON ? NPTS + 1 : 1;
    C1X = 4'(a); C1Y = 4'(b); C2X = 4'(c); C2Y = 4'(d);
    for (int k = 0; k < NPTS; k++) feed_q.push_back({4'(bm_x[k]), 4'(bm_y[k])});
    feed_q.push_back(8'h00);
    r.c1x = 4'(a); r.c1y = 4'(b); r.c2x = 4'(c); r.c2y = 4'(d);
    r.score = SCORE_ON ? 6'(model_score(a, b, c, d)) : 6'd0;
    res_q.push_back(r);

    go = 1'b1;
    tick();
    go = 1'b0;
    if (gate_write) begin
      wr_en = 1'b1; wr_idx = 6'd0; wr_x = 4'd9; wr_y = 4'd9;
      tick();
      wr_en = 1'b0;
    end
    DONE = 1'b1;
    tick();
    if (!stale) DONE = 1'b0;
    while (feed_q.size() > 0) begin
      e = feed_q.pop_front();
      n_tests++;
      if ({X, Y} !== e) begin
        n_fail++;
        $display("FAIL %s feed: got %h expected %h (remaining %0d)", name, {X, Y}, e, feed_q.size());
      end
      tick();
    end

    if (stale) begin
      repeat (5) tick();
      n_tests++;
      if ({res_c1x, res_c1y, res_c2x, res_c2y} !== prev_res || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s stale_done: res %h busy %b expected res %h busy 1", name,
                 {res_c1x, res_c1y, res_c2x, res_c2y}, busy, prev_res);
      end
      DONE = 1'b0;
      tick();
    end
    repeat (low_cycles) tick();
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    n_tests++;
    if ({res_c1x, res_c1y, res_c2x, res_c2y} !== {r.c1x, r.c1y, r.c2x, r.c2y}) begin
      n_fail++;
      $display("FAIL %s capture: got %h expected %h", name,
               {res_c1x, res_c1y, res_c2x, res_c2y}, {r.c1x, r.c1y, r.c2x, r.c2y});
    end

    n = 0;
    while (res_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != exp_lat) begin
      n_fail++;
      $display("FAIL %s valid_latency: got %0d expected %0d", name, n, exp_lat);
    end
    r = res_q.pop_front();
    n_tests++;
    if (res_score !== r.score) begin
      n_fail++;
      $display("FAIL %s score: got %0d expected %0d", name, res_score, r.score);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_valid: got %b expected 0", name, busy);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b0 || {res_c1x, res_c1y, res_c2x, res_c2y} !== {r.c1x, r.c1y, r.c2x, r.c2y}) begin
      n_fail++;
      $display("FAIL %s valid_pulse_hold: valid %b res %h expected valid 0 res %h", name,
               res_valid, {res_c1x, res_c1y, res_c2x, res_c2y}, {r.c1x, r.c1y, r.c2x, r.c2y});
    end
    prev_res = {r.c1x, r.c1y, r.c2x, r.c2y};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: busy %b valid %b expected 0 0", busy, res_valid);
    end
    n_tests++;
    if ({X, Y} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_xy: got %h expected 00", {X, Y});
    end
    n_tests++;
    if ({res_c1x, res_c1y, res_c2x, res_c2y, res_score} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_res: got %h expected 0", {res_c1x, res_c1y, res_c2x, res_c2y, res_score});
    end
  endtask

  task automatic test_feed_capture();
    for (int k = 0; k < NPTS; k++) load_point(k, k % 16, (3 * k) % 16);
    run_job("capture", 3, 4, 12, 11, 100, 1'b0, 1'b0);
  endtask

  task automatic test_score();
    int sx [20] = '{3, 4, 5, 6, 7, 2, 1, 0, 3, 3, 3, 3, 3, 3, 3, 3, 4, 5, 6, 2};
    int sy [20] = '{4, 4, 4, 4, 4, 4, 4, 4, 0, 1, 2, 3, 5, 6, 7, 8, 5, 6, 5, 2};
    for (int k = 0; k < 20; k++) load_point(k, sx[k], sy[k]);
    for (int k = 20; k < NPTS; k++) load_point(k, 15, 0);
    run_job("score", 3, 4, 5, 4, 3, 1'b0, 1'b0);
    n_tests++;
    if (res_score !== (SCORE_ON ? 6'd20 : 6'd0)) begin
      n_fail++;
      $display("FAIL score_overlap: got %0d expected %0d", res_score, SCORE_ON ? 20 : 0);
    end
  endtask

  task automatic test_stale_done();
    run_job("stale", 9, 2, 1, 14, 3, 1'b1, 1'b0);
  endtask

  task automatic test_reset_gating();
    go = 1'b1;
    tick();
    go = 1'b0;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midfeed_busy: got %b expected 1", busy);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || {X, Y} !== 8'h00 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midjob_reset: busy %b xy %h valid %b expected 0 00 0", busy, {X, Y}, res_valid);
    end
    n_tests++;
    if ({res_c1x, res_c1y, res_c2x, res_c2y} !== 16'h0000) begin
      n_fail++;
      $display("FAIL midjob_reset_res: got %h expected 0000", {res_c1x, res_c1y, res_c2x, res_c2y});
    end
    prev_res = 16'h0000;
    run_job("gate", 7, 7, 1, 1, 3, 1'b0, 1'b1);
  endtask

  initial begin
    RST = 1'b0; wr_en = 1'b0; wr_idx = 6'd0; wr_x = 4'd0; wr_y = 4'd0;
    go = 1'b0; DONE = 1'b0; C1X = 4'd0; C1Y = 4'd0; C2X = 4'd0; C2Y = 4'd0;
    test_reset();
    test_feed_capture();
    test_score();
    test_stale_done();
    test_reset_gating();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_host.md
# laser_host

Host-side driver for the two-circle laser coverage engine. It buffers a 40-point job written by the system side and streams the points on `X`/`Y` in the slot the engine samples. It captures `C1X/C1Y/C2X/C2Y` on `DONE` and, optionally, scores the result by counting the points covered by either circle. It sits between the job loader or test controller and one coverage engine instance.

## Interface
Parameters:
- `NPTS`, 40: points per job; sets buffer depth and stream length.
- `RADIUS`, 4: coverage radius; a point is covered when dx²+dy² ≤ RADIUS².

Ports:
- `CLK` in 1: single clock; all logic rises on it.
- `RST` in 1: reset, synchronous, active-high.
- `wr_en` in 1: write a point into the buffer.
- `wr_idx` in 6: buffer index, 0..NPTS-1; writes to larger indices are ignored.
- `wr_x`, `wr_y` in 4 each: point coordinates.
- `go` in 1: single-cycle pulse that arms one job.
- `busy` out 1: high from accepted `go` until `res_valid`.
- `X`, `Y` out 4 each: point stream to the engine.
- `DONE` in 1: engine done/ready flag.
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4 each: engine result.
- `res_c1x`, `res_c1y`, `res_c2x`, `res_c2y` out 4 each: captured result.
- `res_score` out 6: number of covered points, 0..NPTS.
- `res_valid` out 1: one-cycle pulse when all result outputs are final.

## Operation
- FSM states: IDLE, WAIT_DONE, FEED, WAIT_RES, SCORE, REPORT.
- IDLE:
  - `wr_en` writes are accepted only here; writes in other states are dropped.
  - `go` moves to WAIT_DONE. If `wr_en` and `go` are high in the same cycle, the write lands first and is part of the job.
- WAIT_DONE: on the edge where `DONE`=1 is sampled, register `X/Y` with point 0, clear `idx` and go to FEED.
- FEED:
  - Each edge advances `idx` and registers point `idx+1` onto `X/Y`, so point k is on the bus for exactly one cycle, k cycles after leaving WAIT_DONE.
  - After point NPTS-1 has been held for one cycle, go to WAIT_RES. `X/Y` return to 0.
- WAIT_RES:
  - `DONE` must first be seen low, then high. The rising edge of `DONE` captures `C1X..C2Y` into the `res_*` registers.
  - A `DONE` that is high on entry and has not yet dropped is ignored.
  - After capture, go to SCORE, or to REPORT when scoring is compiled out.
- SCORE:
  - Evaluates one buffered point per cycle against both captured centres.
  - Per point: dx=|px−cx| and dy=|py−cy| are 4-bit; squares are 8-bit; the sum is 9-bit and is compared with RADIUS² (RADIUS² ≤ 225).
  - A point covered by both circles counts once.
  - Takes NPTS cycles, then goes to REPORT.
- REPORT: pulse `res_valid` for one cycle, drop `busy`, return to IDLE. Result registers hold until the next capture.
- `go` outside IDLE is ignored.
- `RST` mid-job returns the FSM to IDLE. The buffer contents are retained; the buffer is not reset.

## Timing
- Reset values: `busy`=0, `X`=`Y`=0, all `res_*`=0, `res_valid`=0, `idx`=0.
- Stream alignment: point 0 appears the cycle after the `DONE`=1 sample. This matches the engine's one-cycle idle followed by a 40-cycle sampling window.
- FEED length: exactly NPTS cycles, with no gaps and no stalls.
- Result capture: one cycle after the sampled `DONE` rise.
- `res_valid` latency from capture: NPTS+1 cycles with scoring, 1 cycle without.
- `busy` falls in the same cycle that `res_valid` is high.
- No timeout: WAIT_DONE and WAIT_RES wait indefinitely.

## Configuration
- Macro: `LASER_HOST_SCORE_EN`.
- Defined: the SCORE state and the coverage datapath are present, and `res_score` is the computed count.
- Undefined: SCORE is removed, capture goes directly to REPORT, and `res_score` is tied to 0.

## Structure
- Shared package `laser_pkg`:
  - FSM state enum.
  - `NPTS_DEF`=40 and `RADIUS_DEF`=4.
  - Coordinate typedef (4-bit) and point struct {x, y}.
- Sub-module `laser_cover_chk`: combinational check of one point against two centres, returning a covered bit. The sub-module exists only under `LASER_HOST_SCORE_EN`.
- Buffer: NPTS×8-bit register array with a write port and a read port indexed by `idx`.

## Test plan
- Feed alignment:
  - Stimulus: load point k = (k mod 16, (3k) mod 16), pulse `go`, hold `DONE`=1 for one cycle.
  - Required: `X/Y` equal point 0 on the next cycle, then points 1..39 on consecutive cycles, then 0.
- Capture:
  - Stimulus: after FEED, hold `DONE` low 100 cycles, then raise it with C1=(3,4), C2=(12,11).
  - Required: `res_c1x/y`=3/4 and `res_c2x/y`=12/11; with the macro defined, `res_valid` pulses 41 cycles after capture.
- Score with overlap and boundary:
  - Stimulus: 20 points within radius 4 of (3,4), including exact-boundary points (7,4) and (3,0). 20 points at (15,0). C1=(3,4), C2=(5,4).
  - Required: `res_score`=20, with overlapping points counted once.
- Stale DONE:
  - Stimulus: keep `DONE` high through FEED and WAIT_RES entry.
  - Required: no capture until `DONE` goes low and then high again.
- Reset and gating:
  - Stimulus: assert `RST` mid-FEED, then attempt `wr_en` in WAIT_DONE.
  - Required: FSM returns to IDLE, `X`=0, `busy`=0. The write is dropped and buffer contents are unchanged.
- Macro undefined:
  - Stimulus: run the capture scenario.
  - Required: `res_valid` pulses 1 cycle after capture and `res_score`=0.
